// File: rtl/imem_rsp32_if.sv
// -----------------------------------------------------------------------------
// imem_rsp32_if
//   Instruction-fetch request/response bus between the pre-fetch unit (master)
//   and the instruction memory responder (slave).
//
//   Request channel  : ireqvalid (M->S), ireqready (S->M), ireqhpl, ireqaddr
//   Response channel : irspvalid (S->M), irspready (M->S), irsprerr, irspdata
//
//   A request transfers on a cycle where ireqvalid & ireqready are both high;
//   a response transfers on a cycle where irspvalid & irspready are both high.
// -----------------------------------------------------------------------------
interface imem_rsp32_if;
    logic        ireqready;
    logic        ireqvalid;
    logic [1:0]  ireqhpl;
    logic [31:0] ireqaddr;
    logic        irspready;
    logic        irspvalid;
    logic        irsprerr;
    logic [31:0] irspdata;

    modport master (
        input  ireqready,
        output ireqvalid,
        output ireqhpl,
        output ireqaddr,
        output irspready,
        input  irspvalid,
        input  irsprerr,
        input  irspdata
    );

    modport slave (
        output ireqready,
        input  ireqvalid,
        input  ireqhpl,
        input  ireqaddr,
        input  irspready,
        output irspvalid,
        output irsprerr,
        output irspdata
    );
endinterface : imem_rsp32_if

// File: rtl/imem_rsp32.sv
// -----------------------------------------------------------------------------
// imem_rsp32
//   Instruction-bus responder between the pre-fetch unit and a single-port
//   synchronous instruction RAM/ROM. Requests are decoded for range and
//   privilege errors, read from the RAM, carried through a fixed-latency
//   pipeline and returned in order through a fall-through response buffer.
//   A credit counter bounds the number of outstanding requests so the buffer
//   can never overflow and the pipeline never has to stall.
//
// Ports
//   clk_i        in   clock
//   reset_i      in   asynchronous reset, active-high
//   clk_en_i     in   clock enable; all state holds while low
//   ibus         slave request/response bus (see imem_rsp32_if)
//   mem_en_o     out  RAM read enable
//   mem_addr_o   out  RAM word address (C_SIZE_X-2 bits)
//   mem_rdata_i  in   RAM read data, valid the cycle after mem_en_o
//
// Parameters
//   C_LATENCY      accept->response latency in enabled cycles (>= 1)
//   C_RSP_DEPTH_X  log2 of credits / response buffer depth (>= 1)
//   C_BASE_ADDR    byte base of the region, aligned to 2**C_SIZE_X
//   C_SIZE_X       log2 of region size in bytes (3..31)
//   C_PRIV_SIZE    bytes at region bottom reserved to non-user privilege
// -----------------------------------------------------------------------------
module imem_rsp32 #(
    parameter int unsigned C_LATENCY     = 1,
    parameter int unsigned C_RSP_DEPTH_X = 2,
    parameter logic [31:0] C_BASE_ADDR   = 32'h0,
    parameter int unsigned C_SIZE_X      = 14,
    parameter logic [31:0] C_PRIV_SIZE   = 32'h0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clk_en_i,
    imem_rsp32_if.slave         ibus,
    output logic                mem_en_o,
    output logic [C_SIZE_X-3:0] mem_addr_o,
    input  logic [31:0]         mem_rdata_i
);

    localparam int unsigned    DEPTH      = 1 << C_RSP_DEPTH_X;
    localparam int unsigned    PW         = C_RSP_DEPTH_X;
    localparam int unsigned    CW         = C_RSP_DEPTH_X + 1;
    localparam logic [CW-1:0]  CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
    localparam logic [31:0]    REGION_TAG = C_BASE_ADDR >> C_SIZE_X;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic [31:0] word_addr;
    logic [31:0] offset;
    logic        in_range;
    logic        priv_err;
    logic        req_err;
    logic        req_ready;
    logic        accept;
    logic        pop;

    // Address bits [1:0] are ignored: fetches are always whole words.
    assign word_addr = ibus.ireqaddr & 32'hFFFF_FFFC;
    assign offset    = word_addr - C_BASE_ADDR;

    // The region is size-aligned, so membership is a compare of the upper bits.
    assign in_range  = (word_addr >> C_SIZE_X) == REGION_TAG;
    assign priv_err  = (ibus.ireqhpl == 2'b00) && (offset < C_PRIV_SIZE);
    assign req_err   = ~in_range | priv_err;

    // -------------------------------------------------------------------------
    // Credit counter: requests accepted and not yet popped
    // -------------------------------------------------------------------------
    logic [CW-1:0] count_q, count_d;

    // Ready is a pure decode of registered state, so there is no combinational
    // path from ireqvalid or irspready back to ireqready.
    assign req_ready      = (count_q != CNT_FULL);
    assign ibus.ireqready = req_ready;
    assign accept         = clk_en_i & ibus.ireqvalid & req_ready;

    // Erroneous requests never touch the RAM.
    assign mem_en_o   = accept & ~req_err;
    assign mem_addr_o = ibus.ireqaddr[C_SIZE_X-1:2];

    // -------------------------------------------------------------------------
    // Fixed-latency pipeline. Stage 1 data is the RAM output itself; later
    // stages register it. The pipeline only advances on enabled cycles and
    // never stalls for back-pressure: credits guarantee buffer room.
    // -------------------------------------------------------------------------
    logic [C_LATENCY-1:0]       stg_vld_q;
    logic [C_LATENCY-1:0]       stg_err_q;
    logic [C_LATENCY-1:0][31:0] stg_data;

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: registers take non-blocking assignments so each stage samples
        // the value its neighbour held before the edge.
        if (reset_i) begin
            stg_vld_q <= '0;
            stg_err_q <= '0;
        end else if (clk_en_i) begin
            stg_vld_q[0] <= accept;
            stg_err_q[0] <= req_err;
            for (int unsigned k = 1; k < C_LATENCY; k++) begin
                stg_vld_q[k] <= stg_vld_q[k-1];
                stg_err_q[k] <= stg_err_q[k-1];
            end
        end
    end

    // An error entry carries all-zero data; the RAM output is ignored for it.
    assign stg_data[0] = stg_err_q[0] ? 32'h0 : mem_rdata_i;

    for (genvar g = 1; g < C_LATENCY; g++) begin : g_stage
        logic [31:0] data_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                data_q <= '0;
            end else if (clk_en_i) begin
                data_q <= stg_data[g-1];
            end
        end

        assign stg_data[g] = data_q;
    end

    rsp_t last_rsp;
    logic last_vld;

    assign last_vld      = stg_vld_q[C_LATENCY-1];
    assign last_rsp.err  = stg_err_q[C_LATENCY-1];
    assign last_rsp.data = stg_data[C_LATENCY-1];

    // -------------------------------------------------------------------------
    // Response buffer: circular FIFO with fall-through when empty
    // -------------------------------------------------------------------------
    rsp_t          fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          fifo_empty;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          bypass;
    logic          rsp_vld;
    rsp_t          head;

    assign fifo_empty = (fill_q == '0);

    // Anything older always sits in the FIFO, so when it is empty the
    // pipeline output is the oldest response and is presented directly.
    assign rsp_vld = ~fifo_empty | last_vld;
    assign head    = fifo_empty ? last_rsp : fifo_q[rd_ptr_q];
    assign pop     = clk_en_i & rsp_vld & ibus.irspready;

    // A pipeline entry popped straight from the bypass never enters the FIFO;
    // every other entry leaving the pipeline is stored, which is what keeps
    // the presented response stable while the requester stalls.
    assign bypass  = fifo_empty & pop;
    assign fifo_wr = clk_en_i & last_vld & ~bypass;
    assign fifo_rd = pop & ~fifo_empty;

    assign ibus.irspvalid = rsp_vld;
    assign ibus.irsprerr  = rsp_vld & head.err;
    assign ibus.irspdata  = rsp_vld ? head.data : 32'h0;

    // NOTE: the storage array has no reset; pointers and fill count alone say
    // which entries are meaningful, and the output is masked when invalid.
    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            fifo_q[wr_ptr_q] <= last_rsp;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state for credits, fill level and pointers
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        count_d  = count_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        unique case ({accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: ;
        endcase

        unique case ({fifo_wr, fifo_rd})
            2'b10:   fill_d = fill_q + CNT_ONE;
            2'b01:   fill_d = fill_q - CNT_ONE;
            default: ;
        endcase

        // Pointers are exactly PW bits wide, so they wrap modulo the depth.
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q  <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule : imem_rsp32

// File: tb/tb_imem_rsp32.sv
// -----------------------------------------------------------------------------
// tb_imem_rsp32
//   Self-checking bench for imem_rsp32 (latency 2, 4 credits, 16 KB region at
//   address 0, 256-byte privileged area). A behavioural model keeps a queue of
//   expected responses, each tagged with the enabled-cycle count at which it
//   becomes visible; a compare process checks the DUT against it on every
//   falling edge. Directed sequences pin the model with literal values, then a
//   randomized phase exercises back-pressure, clock enable and errors.
// -----------------------------------------------------------------------------
module tb_imem_rsp32;

    localparam int unsigned LAT  = 2;
    localparam int unsigned DX   = 2;
    localparam int unsigned SZX  = 14;
    localparam int unsigned CRED = 1 << DX;
    localparam logic [31:0] PRIV = 32'h100;
    localparam logic [31:0] SIZE = 32'h4000;

    logic              clk_i   = 1'b0;
    logic              reset_i = 1'b1;
    logic              clk_en_i;
    logic              mem_en_o;
    logic [SZX-3:0]    mem_addr_o;
    logic [31:0]       mem_rdata_i = 32'h0;

    imem_rsp32_if ibus ();

    imem_rsp32 #(
        .C_LATENCY     (LAT),
        .C_RSP_DEPTH_X (DX),
        .C_BASE_ADDR   (32'h0),
        .C_SIZE_X      (SZX),
        .C_PRIV_SIZE   (PRIV)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (clk_en_i),
        .ibus        (ibus),
        .mem_en_o    (mem_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous RAM: output holds when not enabled.
    logic [31:0] ram [4096];
    always @(posedge clk_i) begin
        if (mem_en_o) mem_rdata_i <= ram[mem_addr_o];
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    typedef struct {
        logic        err;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned outstanding = 0;
    int unsigned en_cnt      = 0;

    function automatic logic is_err(input logic [31:0] a, input logic [1:0] h);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return (w >= SIZE) || ((h == 2'b00) && (w < PRIV));
    endfunction

    function automatic logic m_valid();
        return (exp_q.size() > 0) && (exp_q[0].due <= en_cnt);
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            exp_q.delete();
            outstanding = 0;
        end else if (clk_en_i) begin
            logic pp, acc;
            exp_t e;
            logic [31:0] w;
            pp  = m_valid() && ibus.irspready;
            acc = ibus.ireqvalid && (outstanding != CRED);
            if (pp) begin
                void'(exp_q.pop_front());
                outstanding--;
            end
            if (acc) begin
                w      = ibus.ireqaddr;
                e.err  = is_err(ibus.ireqaddr, ibus.ireqhpl);
                e.data = e.err ? 32'h0 : ram[w[13:2]];
                e.due  = en_cnt + LAT;
                exp_q.push_back(e);
                outstanding++;
            end
            en_cnt++;
        end
    end

    always @(negedge clk_i) begin
        if (mon_en) begin
            logic ev, em;
            logic [31:0] a;
            ev = m_valid();
            a  = ibus.ireqaddr;
            check1("ireqready", ibus.ireqready, outstanding != CRED);
            check1("irspvalid", ibus.irspvalid, ev);
            if (ev) begin
                check1("irsprerr", ibus.irsprerr, exp_q[0].err);
                check32("irspdata", ibus.irspdata, exp_q[0].data);
            end
            em = clk_en_i && ibus.ireqvalid && (outstanding != CRED)
                 && !is_err(ibus.ireqaddr, ibus.ireqhpl);
            check1("mem_en", mem_en_o, em);
            if (em) check32("mem_addr", 32'(mem_addr_o), 32'(a[13:2]));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [1:0] h);
        ibus.ireqvalid = 1'b1;
        ibus.ireqaddr  = a;
        ibus.ireqhpl   = h;
    endtask

    task automatic idle();
        ibus.ireqvalid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic e, input logic [31:0] d);
        check1({tag, "_valid"}, ibus.irspvalid, 1'b1);
        check1({tag, "_rerr"}, ibus.irsprerr, e);
        check32({tag, "_data"}, ibus.irspdata, d);
    endtask

    // Three back-to-back fetches with irspready high and nothing pending;
    // responses appear two cycles after their accept, one per cycle.
    task automatic burst3(input string tag,
                          input logic [31:0] a0, input logic [1:0] h0, input logic e0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [1:0] h1, input logic e1, input logic [31:0] d1,
                          input logic [31:0] a2, input logic [1:0] h2, input logic e2, input logic [31:0] d2);
        req(a0, h0); #1; check1({tag, "_mem_en0"}, mem_en_o, !e0); step();
        req(a1, h1); #1; check1({tag, "_mem_en1"}, mem_en_o, !e1); step();
        check_rsp({tag, "_r0"}, e0, d0);
        check1({tag, "_ready0"}, ibus.ireqready, 1'b1);
        req(a2, h2); #1; check1({tag, "_mem_en2"}, mem_en_o, !e2); step();
        check_rsp({tag, "_r1"}, e1, d1);
        idle(); step();
        check_rsp({tag, "_r2"}, e2, d2);
        step();
        check1({tag, "_drained"}, ibus.irspvalid, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        int unsigned n_acc;

        for (int i = 0; i < 4096; i++) ram[i] = $urandom;
        ram[12'h000] = 32'h0000_1000;
        ram[12'h001] = 32'h0000_1001;
        ram[12'h002] = 32'h0000_1002;
        ram[12'h010] = 32'hC0DE_0040;
        ram[12'h011] = 32'hC0DE_0044;
        ram[12'h020] = 32'hBEEF_0080;
        ram[12'h040] = 32'hBEEF_0100;
        for (int k = 0; k < 4; k++) ram[12'h080 + k] = 32'hD00D_0000 + 32'(k);

        clk_en_i       = 1'b1;
        ibus.ireqvalid = 1'b0;
        ibus.ireqhpl   = 2'b00;
        ibus.ireqaddr  = 32'h0;
        ibus.irspready = 1'b1;

        // Reset values
        #2;
        check1("rst_ireqready", ibus.ireqready, 1'b1);
        check1("rst_irspvalid", ibus.irspvalid, 1'b0);
        check1("rst_irsprerr", ibus.irsprerr, 1'b0);
        check32("rst_irspdata", ibus.irspdata, 32'h0);
        check1("rst_mem_en", mem_en_o, 1'b0);
        mon_en = 1'b1;
        step(); step();
        reset_i = 1'b0;
        step();

        // Back-to-back good fetches
        burst3("t1", 32'h0, 2'b11, 1'b0, 32'h0000_1000,
                     32'h4, 2'b11, 1'b0, 32'h0000_1001,
                     32'h8, 2'b11, 1'b0, 32'h0000_1002);

        // Out-of-range fetch between two good ones
        burst3("t3", 32'h40,        2'b11, 1'b0, 32'hC0DE_0040,
                     32'h0001_0000, 2'b11, 1'b1, 32'h0,
                     32'h44,        2'b11, 1'b0, 32'hC0DE_0044);

        // Privileged area
        burst3("t4", 32'h80,  2'b00, 1'b1, 32'h0,
                     32'h80,  2'b11, 1'b0, 32'hBEEF_0080,
                     32'h100, 2'b00, 1'b0, 32'hBEEF_0100);

        // Credit exhaustion under back-pressure
        ibus.irspready = 1'b0;
        n_acc = 0;
        a = 32'h200;
        for (int i = 0; i < 6; i++) begin
            req(a, 2'b11);
            if (i >= 4) check1("t2_ready_low", ibus.ireqready, 1'b0);
            if (ibus.ireqready) begin
                n_acc++;
                a += 32'h4;
            end
            step();
        end
        idle();
        check32("t2_accepted", 32'(n_acc), 32'd4);
        check1("t2_full_ready", ibus.ireqready, 1'b0);
        ibus.irspready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_rsp("t2_drain", 1'b0, 32'hD00D_0000 + 32'(k));
            step();
            if (k == 0) check1("t2_ready_after_pop", ibus.ireqready, 1'b1);
        end
        check1("t2_drained", ibus.irspvalid, 1'b0);

        // Reset with responses outstanding
        ibus.irspready = 1'b0;
        req(32'h0, 2'b11); step();
        req(32'h4, 2'b11); step();
        req(32'h8, 2'b11); step();
        idle();
        reset_i = 1'b1;
        #1;
        check1("t5_rst_valid", ibus.irspvalid, 1'b0);
        check1("t5_rst_ready", ibus.ireqready, 1'b1);
        step(); step();
        reset_i = 1'b0;
        ibus.irspready = 1'b1;
        step();
        req(32'h4, 2'b11); step();
        idle(); step();
        check_rsp("t5_r", 1'b0, 32'h0000_1001);
        step();
        check1("t5_only_one", ibus.irspvalid, 1'b0);

        // Clock enable low for two cycles mid-stream
        req(32'h0, 2'b11); step();
        req(32'h4, 2'b11); step();
        idle();
        clk_en_i = 1'b0;
        req(32'h8, 2'b11); #1;
        check1("t6_mem_en_off", mem_en_o, 1'b0);
        idle();
        step();
        check_rsp("t6_hold0", 1'b0, 32'h0000_1000);
        step();
        check_rsp("t6_hold1", 1'b0, 32'h0000_1000);
        clk_en_i = 1'b1;
        step();
        check_rsp("t6_r1", 1'b0, 32'h0000_1001);
        step();
        check1("t6_drained", ibus.irspvalid, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            clk_en_i       = ($urandom_range(0, 9) != 0);
            ibus.irspready = ($urandom_range(0, 3) != 0);
            ibus.ireqvalid = ($urandom_range(0, 2) != 0);
            ibus.ireqhpl   = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 5)      ibus.ireqaddr = ($urandom_range(0, 4095) << 2) | 32'($urandom_range(0, 3));
            else if (r < 8) ibus.ireqaddr = 32'($urandom_range(0, 511));
            else            ibus.ireqaddr = $urandom;
            if (c == 1500) begin
                ibus.ireqvalid = 1'b0;
                reset_i = 1'b1;
                step();
                reset_i = 1'b0;
            end
            step();
        end

        idle();
        clk_en_i       = 1'b1;
        ibus.irspready = 1'b1;
        repeat (10) step();
        check1("final_idle", ibus.irspvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_rsp32
